// File: rtl/fp32_to_bf16_packer_pkg.sv
// Shared fp32/bf16 field layout and constants for the FMA result path.
package fp32_to_bf16_packer_pkg;

   localparam int FP32_W      = 32;
   localparam int BF16_W      = 16;
   localparam int FP_EXP_W    = 8;
   localparam int FP32_MANT_W = 23;
   localparam int BF16_MANT_W = 7;

   localparam logic [FP_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;
   localparam logic [BF16_W-1:0]   BF16_QNAN    = 16'h7FC0;

   typedef struct packed {
      logic                   sign;
      logic [FP_EXP_W-1:0]    exp;
      logic [FP32_MANT_W-1:0] mant;
   } fp32_t;

   typedef struct packed {
      logic                   sign;
      logic [FP_EXP_W-1:0]    exp;
      logic [BF16_MANT_W-1:0] mant;
   } bf16_t;

endpackage

// File: rtl/fp32_to_bf16_packer_rne.sv
// Combinational fp32 -> bf16 narrowing with round-to-nearest-even and an inexact flag.
module fp32_to_bf16_rne
   import fp32_to_bf16_packer_pkg::*;
(
   input  logic [FP32_W-1:0] fpIn,
   output logic [BF16_W-1:0] bfOut,
   output logic              inexact
);

   fp32_t fpFields;

   // Carry out of the mantissa rolls into the exponent, so max-finite rounds to Inf.
   function automatic logic [BF16_W-1:0] roundNearestEven(input logic [FP32_W-1:0] v);
      logic roundUp;
      roundUp = v[15] & ((|v[14:0]) | v[16]);
      return v[31:16] + {15'd0, roundUp};
   endfunction

   assign fpFields = fpIn;

   always_comb begin
      bfOut   = {fpFields.sign, 15'h0000};
      inexact = 1'b0;
      if (fpFields.exp == FP32_EXP_MAX) begin
         if (fpFields.mant != '0) begin
            bfOut = BF16_QNAN;
         end else begin
            bfOut = fpIn[31:16];
         end
      end else if (fpFields.exp == '0) begin
         // Denormals flush to signed zero.
         inexact = (fpFields.mant != '0);
      end else begin
         bfOut   = roundNearestEven(fpIn);
         inexact = |fpIn[15:0];
      end
   end

endmodule

// File: rtl/fp32_to_bf16_packer.sv
// Narrows a stream of fp32 values to bf16 and packs PACK lanes per output word.
module fp32_to_bf16_packer
   import fp32_to_bf16_packer_pkg::*;
#(
   parameter int PACK  = 2,
   parameter int CNT_W = 16
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FP32_W-1:0]        in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BF16_W*PACK-1:0]   out_data,
   output logic [PACK-1:0]          out_keep,
   output logic                     out_last,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         inexact_cnt
);

   localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

   logic [BF16_W-1:0]      laneBf16;
   logic                   laneInexact;
   logic                   inBeat;
   logic                   wordDone;
   logic [BF16_W*PACK-1:0] mergedData;
   logic [PACK-1:0]        mergedKeep;

   logic [BF16_W*PACK-1:0] packData_p0;
   logic [PACK-1:0]        packKeep_p0;
   logic [IDX_W-1:0]       laneIdx_p0;

   logic [BF16_W*PACK-1:0] outData_p1;
   logic [PACK-1:0]        outKeep_p1;
   logic                   outLast_p1;
   logic                   vld_p1;
   logic [CNT_W-1:0]       inexactCnt;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   fp32_to_bf16_rne uRne (
      .fpIn    (in_data),
      .bfOut   (laneBf16),
      .inexact (laneInexact)
   );

   assign in_ready = !vld_p1 | out_ready;
   assign inBeat   = in_valid & in_ready;
   assign wordDone = inBeat & ((laneIdx_p0 == IDX_W'(PACK-1)) | in_last);

   always_comb begin
      mergedData = packData_p0;
      mergedKeep = packKeep_p0;
      for (int i = 0; i < PACK; i++) begin
         if (laneIdx_p0 == IDX_W'(i)) begin
            mergedData[BF16_W*i +: BF16_W] = laneBf16;
            mergedKeep[i]                  = 1'b1;
         end
      end
   end

   // Stage p0: lane accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packData_p0 <= '0;
         packKeep_p0 <= '0;
         laneIdx_p0  <= '0;
      end else if (wordDone) begin
         packData_p0 <= '0;
         packKeep_p0 <= '0;
         laneIdx_p0  <= '0;
      end else if (inBeat) begin
         packData_p0 <= mergedData;
         packKeep_p0 <= mergedKeep;
         laneIdx_p0  <= laneIdx_p0 + IDX_W'(1);
      end
   end

   // Stage p1: output word register; a completing beat reloads it even while it drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outData_p1 <= '0;
         outKeep_p1 <= '0;
         outLast_p1 <= 1'b0;
         vld_p1     <= 1'b0;
      end else if (wordDone) begin
         outData_p1 <= mergedData;
         outKeep_p1 <= mergedKeep;
         outLast_p1 <= in_last;
         vld_p1     <= 1'b1;
      end else if (out_ready) begin
         vld_p1     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inexactCnt <= '0;
      end else if (cnt_clr) begin
         inexactCnt <= '0;
      end else if (inBeat & laneInexact) begin
         inexactCnt <= satInc(inexactCnt);
      end
   end

   assign out_valid   = vld_p1;
   assign out_data    = outData_p1;
   assign out_keep    = outKeep_p1;
   assign out_last    = outLast_p1;
   assign inexact_cnt = inexactCnt;

endmodule

// File: tb/tb_fp32_to_bf16_packer.sv
// Self-checking bench for fp32_to_bf16_packer with a queue-based reference model.
module tb_fp32_to_bf16_packer;

   localparam int PACK  = 2;
   localparam int CNT_W = 16;
   localparam int OW    = 16 * PACK;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_data;
   logic [PACK-1:0] out_keep;
   logic            out_last;
   logic            cnt_clr;
   logic [CNT_W-1:0] inexact_cnt;

   typedef struct {
      logic [OW-1:0]   data;
      logic [PACK-1:0] keep;
      logic            last;
   } word_t;

   word_t       expQ[$];
   logic [15:0] laneQ[$];
   int          modelCnt;
   int          passed;
   int          total;
   int          wordsOut;
   bit          lastInBeat;
   logic [31:0] bpVals[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

   always #5 clk = ~clk;

   fp32_to_bf16_packer #(.PACK(PACK), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_keep    (out_keep),
      .out_last    (out_last),
      .cnt_clr     (cnt_clr),
      .inexact_cnt (inexact_cnt)
   );

   // {inexact, bf16}: rounding done on the integer value of the discarded half
   function automatic logic [16:0] refConvert(input logic [31:0] x);
      int unsigned hi;
      int unsigned lo;
      hi = {16'h0, x[31:16]};
      lo = {16'h0, x[15:0]};
      if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? {1'b0, 16'h7FC0} : {1'b0, x[31:16]};
      if (x[30:23] == 8'h00) return {x[22:0] != 0, x[31], 15'h0000};
      if (lo > 32768 || (lo == 32768 && hi % 2 == 1)) hi = hi + 1;
      return {lo != 0, hi[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic modelReset();
      laneQ.delete();
      expQ.delete();
      modelCnt = 0;
   endtask

   task automatic tick();
      logic        inB;
      logic        outB;
      logic [16:0] r;
      word_t       w;
      #1;
      inB  = in_valid & in_ready;
      outB = out_valid & out_ready;
      if (outB) begin
         chk("word_pending", 64'(expQ.size() > 0), 64'd1);
         if (expQ.size() > 0) begin
            w = expQ.pop_front();
            chk("out_data", 64'(out_data), 64'(w.data));
            chk("out_keep", 64'(out_keep), 64'(w.keep));
            chk("out_last", 64'(out_last), 64'(w.last));
            wordsOut++;
         end
      end
      if (inB) begin
         r = refConvert(in_data);
         laneQ.push_back(r[15:0]);
         if (!cnt_clr && r[16] && modelCnt < (1 << CNT_W) - 1) modelCnt++;
         if (laneQ.size() == PACK || in_last) begin
            w.data = '0;
            w.keep = '0;
            foreach (laneQ[i]) begin
               w.data[16*i +: 16] = laneQ[i];
               w.keep[i]          = 1'b1;
            end
            w.last = in_last;
            expQ.push_back(w);
            laneQ.delete();
         end
      end
      if (cnt_clr) modelCnt = 0;
      lastInBeat = inB;
      @(posedge clk);
      #1;
   endtask

   task automatic sendBeat(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (lastInBeat) break;
      end
      chk("beat_accepted", 64'(lastInBeat), 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic clearCnt();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("cnt_cleared", 64'(inexact_cnt), 64'd0);
   endtask

   task automatic checkWord(input string tag, input logic [OW-1:0] d,
                            input logic [PACK-1:0] k, input logic l);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_data"},  64'(out_data),  64'(d));
      chk({tag, "_keep"},  64'(out_keep),  64'(k));
      chk({tag, "_last"},  64'(out_last),  64'(l));
   endtask

   initial begin
      int k;
      logic [31:0] d;
      passed    = 0;
      total     = 0;
      wordsOut  = 0;
      modelCnt  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_keep",  64'(out_keep),  64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      chk("rst_cnt",       64'(inexact_cnt), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic pack: exact then inexact lane
      clearCnt();
      sendBeat(32'h3F800000, 1'b0);
      sendBeat(32'h40490FDB, 1'b0);
      checkWord("pi_word", 32'h40493F80, 2'b11, 1'b0);
      chk("pi_cnt", 64'(inexact_cnt), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Ties to even
      clearCnt();
      sendBeat(32'h3F808000, 1'b0);
      sendBeat(32'h3F818000, 1'b0);
      checkWord("tie_word", 32'h3F823F80, 2'b11, 1'b0);
      chk("tie_cnt", 64'(inexact_cnt), 64'd2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Specials
      clearCnt();
      sendBeat(32'h7F7FFFFF, 1'b0);
      sendBeat(32'hFFC00001, 1'b0);
      checkWord("ovf_nan_word", 32'h7FC07F80, 2'b11, 1'b0);
      chk("ovf_nan_cnt", 64'(inexact_cnt), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      sendBeat(32'h80000001, 1'b0);
      sendBeat(32'hFF800000, 1'b0);
      checkWord("den_inf_word", 32'hFF808000, 2'b11, 1'b0);
      chk("den_inf_cnt", 64'(inexact_cnt), 64'd2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Partial flush
      sendBeat(32'h3F800000, 1'b1);
      checkWord("flush_word", 32'h00003F80, 2'b01, 1'b1);
      out_ready = 1'b1;
      tick();

      // Backpressure: downstream stalls for the first 5 cycles
      k = 0;
      wordsOut = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (k < 6);
         in_data   = bpVals[(k < 6) ? k : 5];
         in_last   = 1'b0;
         if (cyc == 3) begin
            #1;
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         end
         tick();
         if (lastInBeat) k++;
         if (k == 6 && expQ.size() == 0) break;
      end
      in_valid = 1'b0;
      chk("bp_all_sent", 64'(k), 64'd6);
      chk("bp_words", 64'(wordsOut), 64'd3);

      // Reset with a partial lane held
      out_ready = 1'b1;
      sendBeat(32'h3F800000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_cnt",   64'(inexact_cnt), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      sendBeat(32'h40490FDB, 1'b0);
      sendBeat(32'h3F800000, 1'b0);
      checkWord("post_rst_word", 32'h3F804049, 2'b11, 1'b0);

      // Reset with a pending output word
      #1 rst_n = 1'b0;
      #1;
      modelReset();
      chk("rst_pend_valid", 64'(out_valid), 64'd0);
      chk("rst_pend_data",  64'(out_data),  64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Counter saturation and clear priority
      clearCnt();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h3F800001;
      in_last   = 1'b0;
      for (int i = 0; i < 65540; i++) tick();
      chk("cnt_saturated", 64'(inexact_cnt), 64'hFFFF);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      chk("cnt_clr_priority", 64'(inexact_cnt), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         d = $urandom;
         case ($urandom % 4)
            0: d[30:23] = 8'hFF;
            1: d[30:23] = 8'h00;
            2: d[15:0]  = 16'h8000;
            default: ;
         endcase
         in_valid  = ($urandom % 4) != 0;
         in_data   = d;
         in_last   = ($urandom % 5) == 0;
         out_ready = ($urandom % 3) != 0;
         cnt_clr   = ($urandom % 50) == 0;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      cnt_clr  = 1'b0;
      chk("rand_cnt", 64'(inexact_cnt), 64'(modelCnt));
      out_ready = 1'b1;
      if (laneQ.size() > 0) sendBeat(32'h3F800000, 1'b1);
      for (int n = 0; n < 20; n++) begin
         if (expQ.size() == 0) break;
         tick();
      end
      chk("drain_empty", 64'(expQ.size()), 64'd0);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
